// File: rtl/alu_opfetch.sv
// Operand-fetch / write-back stage wrapped around an external combinational ALU.
// Holds the register file, registers ALU operands for one cycle, writes the
// result (or a LOADI immediate) back on the following edge, and forwards the
// in-flight result to a dependent instruction issuing on that same edge.
module alu_opfetch #(
  parameter int W    = 32,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_op,
  input  logic [2:0]    in_f,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [W-1:0]  in_imm,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_f,
  input  logic [W-1:0]  alu_r,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [W-1:0]  wb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  typedef enum logic [0:0] {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic            e_valid;
  logic            e_op;
  logic [AW-1:0]   e_rd;
  logic [W-1:0]    e_imm;
  logic [W-1:0]    regfile [NREG];
  logic            accept;
  logic [W-1:0]    fwd_rs;
  logic [W-1:0]    fwd_rt;

  // Write-back view of the E stage and operand forwarding
  always_comb begin
    accept   = in_valid && in_ready;
    wb_valid = e_valid && (e_rd != '0);
    wb_rd    = e_rd;
    wb_data  = e_op ? e_imm : alu_r;

    if (in_rs == '0)
      fwd_rs = '0;
    else if (wb_valid && (wb_rd == in_rs))
      fwd_rs = wb_data;
    else
      fwd_rs = regfile[in_rs];

    if (in_rt == '0)
      fwd_rt = '0;
    else if (wb_valid && (wb_rd == in_rt))
      fwd_rt = wb_data;
    else
      fwd_rt = regfile[in_rt];
  end

  // Debug read port; R0 is hardwired to zero
  always_comb begin
    dbg_data = (dbg_addr == '0) ? '0 : regfile[dbg_addr];
  end

  // Control FSM, E stage and registered ALU operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      clr_cnt  <= '0;
      in_ready <= 1'b0;
      e_valid  <= 1'b0;
      // E looks like a LOADI of zero after reset so wb_data reads 0
      // independent of what the external ALU does with zero operands.
      e_op     <= 1'b1;
      e_rd     <= '0;
      e_imm    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_f    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(NREG - 1)) begin
            state    <= S_RUN;
            in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          in_ready <= 1'b1;
        end
        default: begin
          state    <= S_INIT;
          clr_cnt  <= '0;
          in_ready <= 1'b0;
        end
      endcase

      e_valid <= accept;
      if (accept) begin
        e_op  <= in_op;
        e_rd  <= in_rd;
        e_imm <= in_imm;
        alu_a <= in_op ? in_imm : fwd_rs;
        alu_b <= in_op ? '0 : fwd_rt;
        alu_f <= in_f;
      end
    end
  end

  // Register array: cleared one entry per cycle in INIT, written back in RUN
  always_ff @(posedge clk) begin
    if (state == S_INIT)
      regfile[clr_cnt] <= '0;
    else if (wb_valid)
      regfile[wb_rd] <= wb_data;
  end

endmodule

// File: tb/tb_alu_opfetch.sv
// Self-checking bench for alu_opfetch with a behavioural stand-in for the ALU.
`timescale 1ns/100ps
module tb_alu_opfetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [2:0]  in_f;
  logic [2:0]  in_rd, in_rs, in_rt;
  logic [31:0] in_imm;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_f;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural register state, updated in program order at issue
  logic [31:0] m [8];

  always #5 clk = ~clk;

  alu_opfetch #(.W(32), .NREG(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_f(in_f), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_r(alu_r),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU function set: AND, OR, ADD, XOR, AND-NOT, OR-NOT, SUB, signed SLT
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f);
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a ^ b;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_a, alu_b, alu_f);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdm(input logic [2:0] x);
    return (x == 3'd0) ? 32'd0 : m[x];
  endfunction

  // Program-order semantics of one instruction
  task automatic model_exec(input logic op, input logic [2:0] f, input logic [2:0] rd,
                            input logic [2:0] rs, input logic [2:0] rt, input logic [31:0] imm);
    logic [31:0] v;
    v = op ? imm : alu_fn(rdm(rs), rdm(rt), f);
    if (rd != 3'd0) m[rd] = v;
  endtask

  task automatic scramble_idle();
    in_valid = 1'b0;
    in_op    = 1'($urandom);
    in_f     = 3'($urandom);
    in_rd    = 3'($urandom);
    in_rs    = 3'($urandom);
    in_rt    = 3'($urandom);
    in_imm   = $urandom;
  endtask

  // Offer one instruction at posedge+1, let it be accepted, return at posedge+1
  task automatic issue(input logic op, input logic [2:0] f, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [31:0] imm);
    in_valid = 1'b1;
    in_op = op; in_f = f; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    chk("in_ready_at_issue", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    scramble_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    while (!in_ready && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic chk_regs(input string nm);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(nm, dbg_data, rdm(3'(i)));
    end
  endtask

  typedef struct {
    logic        op;
    logic [2:0]  f;
    logic [2:0]  rd, rs, rt;
    logic [31:0] imm;
    logic [31:0] ea, eb;
    logic        ewv;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    logic        op;
    logic [2:0]  f, rd, rs, rt;
    logic [31:0] imm, ea, eb;

    //           op    f     rd    rs    rt    imm     a       b      wbv   wbd
    tbl[0] = '{1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'd7, 32'd7,  32'd0, 1'b1, 32'd7};
    tbl[1] = '{1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd5, 32'd5,  32'd0, 1'b1, 32'd5};
    tbl[2] = '{1'b0, 3'd2, 3'd3, 3'd1, 3'd2, 32'd0, 32'd7,  32'd5, 1'b1, 32'd12};
    tbl[3] = '{1'b0, 3'd6, 3'd4, 3'd3, 3'd1, 32'd0, 32'd12, 32'd7, 1'b1, 32'd5};
    tbl[4] = '{1'b0, 3'd2, 3'd0, 3'd1, 3'd2, 32'd0, 32'd7,  32'd5, 1'b0, 32'd12};
    tbl[5] = '{1'b0, 3'd2, 3'd5, 3'd0, 3'd2, 32'd0, 32'd0,  32'd5, 1'b1, 32'd5};
    tbl[6] = '{1'b0, 3'd0, 3'd6, 3'd4, 3'd1, 32'd0, 32'd5,  32'd7, 1'b1, 32'd5};
    tbl[7] = '{1'b0, 3'd1, 3'd7, 3'd6, 3'd3, 32'd0, 32'd5,  32'd12, 1'b1, 32'd13};
    tbl[8] = '{1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd3, 32'd3,  32'd0, 1'b1, 32'd3};
    tbl[9] = '{1'b0, 3'd2, 3'd2, 3'd2, 3'd2, 32'd0, 32'd3,  32'd3, 1'b1, 32'd6};

    for (int i = 0; i < 8; i++) m[i] = 32'd0;
    scramble_idle();
    dbg_addr = 3'd0;

    // Reset release and INIT length
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_f", 32'(alu_f), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    wait_ready(c);
    chk("init_cycles", 32'(c), 32'd8);
    chk_regs("init_regs_zero");

    // Directed table: LOADI, forwarding chains, R0 rules
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].f, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].imm);
      model_exec(tbl[i].op, tbl[i].f, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].imm);
      chk("tbl_alu_a", alu_a, tbl[i].ea);
      chk("tbl_alu_b", alu_b, tbl[i].eb);
      chk("tbl_alu_f", 32'(alu_f), 32'(tbl[i].f));
      chk("tbl_wb_valid", 32'(wb_valid), 32'(tbl[i].ewv));
      chk("tbl_wb_data", wb_data, tbl[i].ewd);
      if (tbl[i].ewv) chk("tbl_wb_rd", 32'(wb_rd), 32'(tbl[i].rd));
    end
    idle(1);
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_alu_a_hold", alu_a, 32'd3);
    chk("idle_wb_data_hold", wb_data, 32'd6);
    idle(1);
    chk_regs("tbl_regs");

    // Reset while an instruction sits in E
    @(posedge clk); #1;
    issue(1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 32'd99);
    chk("mid_wb_valid_before", 32'(wb_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wb_valid_in_rst", 32'(wb_valid), 32'd0);
    chk("mid_in_ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m[i] = 32'd0;
    wait_ready(c);
    chk("reinit_cycles", 32'(c), 32'd8);
    chk_regs("reinit_regs_zero");
    @(posedge clk); #1;

    // Randomized instruction stream against the program-order model
    for (int n = 0; n < 1000; n++) begin
      c = int'($urandom_range(0, 2));
      if (c > 0) begin
        idle(c);
        chk("rnd_gap_wb_valid", 32'(wb_valid), 32'd0);
      end
      op  = ($urandom_range(0, 3) == 0);
      f   = 3'($urandom);
      rd  = 3'($urandom);
      rs  = 3'($urandom);
      rt  = 3'($urandom);
      imm = $urandom;
      ea  = op ? imm : rdm(rs);
      eb  = op ? 32'd0 : rdm(rt);
      issue(op, f, rd, rs, rt, imm);
      model_exec(op, f, rd, rs, rt, imm);
      chk("rnd_alu_a", alu_a, ea);
      chk("rnd_alu_b", alu_b, eb);
      chk("rnd_wb_valid", 32'(wb_valid), 32'(rd != 3'd0));
      if (n % 100 == 99) begin
        idle(2);
        chk_regs("rnd_regs");
        @(posedge clk); #1;
      end
    end
    idle(2);
    chk_regs("final_regs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
